// File: rtl/therm_pkg.sv
// Shared types, default temperature-unit constants and the saturation helper
// used by the thermistor scanner.
package therm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_CONV = 2'd2,
    ST_OUT  = 2'd3
  } therm_state_e;

  // Temperatures are in 0.1 degC steps; these defaults map 12-bit codes to that scale.
  localparam int          DEF_GAIN   = -100;
  localparam int          DEF_FRAC   = 4;
  localparam int          DEF_OFFSET = 2000;
  localparam int unsigned DEF_HYST   = 50;
  localparam int          SAT_W      = 64;

  function automatic logic signed [SAT_W-1:0] sat_signed(
    input logic signed [SAT_W-1:0] x,
    input int unsigned             w
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (w - 32'd1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 32'd1));
    if (x > hi) begin
      sat_signed = hi;
    end else if (x < lo) begin
      sat_signed = lo;
    end else begin
      sat_signed = x;
    end
  endfunction

endpackage

// File: rtl/therm_lin.sv
// Combinational linearisation of an averaged ADC code into a saturated,
// signed fixed-point temperature.
module therm_lin
  import therm_pkg::*;
#(
  parameter int V_WIDTH = 12,
  parameter int T_WIDTH = 16,
  parameter int GAIN    = DEF_GAIN,
  parameter int FRAC    = DEF_FRAC,
  parameter int OFFSET  = DEF_OFFSET
) (
  input  logic        [V_WIDTH-1:0] avg,
  output logic signed [T_WIDTH-1:0] t
);

  logic signed [SAT_W-1:0] prod_s;
  logic signed [SAT_W-1:0] sum_s;
  logic signed [SAT_W-1:0] sat_s;
  logic                    unused_sat_hi;

  // Wide signed datapath so neither the product nor the offset can wrap before clamping.
  always_comb begin
    prod_s = $signed({{(SAT_W-V_WIDTH){1'b0}}, avg}) * $signed(SAT_W'(GAIN));
    sum_s  = (prod_s >>> FRAC) + $signed(SAT_W'(OFFSET));
    sat_s  = sat_signed(sum_s, T_WIDTH);
    t      = sat_s[T_WIDTH-1:0];
  end

  assign unused_sat_hi = ^sat_s[SAT_W-1:T_WIDTH];

endmodule

// File: rtl/therm_scanner.sv
// Round-robin multi-channel thermistor scanner: averages ADC samples per channel,
// linearises them and presents results with per-channel hysteretic alarms.
module therm_scanner
  import therm_pkg::*;
#(
  parameter int          CHANNELS = 4,
  parameter int          V_WIDTH  = 12,
  parameter int          T_WIDTH  = 16,
  parameter int          AVG_LOG2 = 2,
  parameter int          GAIN     = DEF_GAIN,
  parameter int          FRAC     = DEF_FRAC,
  parameter int          OFFSET   = DEF_OFFSET,
  parameter int unsigned HYST     = DEF_HYST
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  output logic                        adc_req,
  output logic [$clog2(CHANNELS)-1:0] adc_chan,
  input  logic                        adc_valid,
  input  logic [V_WIDTH-1:0]          adc_data,
  output logic                        temp_valid,
  input  logic                        temp_ready,
  output logic [$clog2(CHANNELS)-1:0] temp_chan,
  output logic signed [T_WIDTH-1:0]   temp_data,
  input  logic signed [T_WIDTH-1:0]   alarm_hi,
  output logic [CHANNELS-1:0]         alarm
);

  localparam int CW    = $clog2(CHANNELS);
  localparam int AW    = V_WIDTH + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int AL_W  = T_WIDTH + 2;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [CW-1:0]    CHAN_LAST = CW'(CHANNELS - 1);

  therm_state_e               state_q, state_d;
  logic [CW-1:0]              chan_q, chan_d;
  logic [AW-1:0]              acc_q, acc_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       adc_req_q, adc_req_d;
  logic                       temp_valid_q, temp_valid_d;
  logic [CW-1:0]              temp_chan_q, temp_chan_d;
  logic signed [T_WIDTH-1:0]  temp_data_q, temp_data_d;
  logic [CHANNELS-1:0]        alarm_q, alarm_d;

  logic [V_WIDTH-1:0]         avg_s;
  logic signed [T_WIDTH-1:0]  t_s;
  logic signed [AL_W-1:0]     t_ext_s, hi_ext_s, lo_ext_s;
  logic                       alarm_set_s, alarm_clr_s;
  logic [CW-1:0]              chan_next_s;

  assign avg_s = V_WIDTH'(acc_q >> AVG_LOG2);

  therm_lin #(
    .V_WIDTH (V_WIDTH),
    .T_WIDTH (T_WIDTH),
    .GAIN    (GAIN),
    .FRAC    (FRAC),
    .OFFSET  (OFFSET)
  ) u_lin (
    .avg (avg_s),
    .t   (t_s)
  );

  // Alarm thresholds; two extra bits keep alarm_hi - HYST from wrapping.
  always_comb begin
    t_ext_s     = AL_W'(t_s);
    hi_ext_s    = AL_W'(alarm_hi);
    lo_ext_s    = hi_ext_s - $signed(AL_W'(HYST));
    alarm_set_s = (t_ext_s >= hi_ext_s);
    alarm_clr_s = (t_ext_s < lo_ext_s);
    if (chan_q == CHAN_LAST) begin
      chan_next_s = {CW{1'b0}};
    end else begin
      chan_next_s = chan_q + CW'(1);
    end
  end

  // Next-state and next-output logic of the scan FSM.
  always_comb begin
    state_d      = state_q;
    chan_d       = chan_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    adc_req_d    = adc_req_q;
    temp_valid_d = temp_valid_q;
    temp_chan_d  = temp_chan_q;
    temp_data_d  = temp_data_q;
    alarm_d      = alarm_q;
    case (state_q)
      ST_IDLE: begin
        adc_req_d = 1'b0;
        if (enable) begin
          state_d   = ST_REQ;
          adc_req_d = 1'b1;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (adc_req_q && adc_valid) begin
          acc_d = acc_q + AW'(adc_data);
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d   = ST_CONV;
            adc_req_d = 1'b0;
          end else begin
            state_d   = ST_REQ;
          end
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_CONV: begin
        temp_data_d  = t_s;
        temp_chan_d  = chan_q;
        temp_valid_d = 1'b1;
        acc_d        = {AW{1'b0}};
        cnt_d        = {CNT_W{1'b0}};
        state_d      = ST_OUT;
        if (alarm_set_s) begin
          alarm_d[chan_q] = 1'b1;
        end else if (alarm_clr_s) begin
          alarm_d[chan_q] = 1'b0;
        end else begin
          alarm_d[chan_q] = alarm_q[chan_q];
        end
      end
      ST_OUT: begin
        if (temp_ready) begin
          temp_valid_d = 1'b0;
          chan_d       = chan_next_s;
          if (enable) begin
            state_d   = ST_REQ;
            adc_req_d = 1'b1;
          end else begin
            state_d   = ST_IDLE;
          end
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        adc_req_d    = 1'b0;
        temp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      chan_q       <= {CW{1'b0}};
      acc_q        <= {AW{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
      adc_req_q    <= 1'b0;
      temp_valid_q <= 1'b0;
      temp_chan_q  <= {CW{1'b0}};
      temp_data_q  <= {T_WIDTH{1'b0}};
      alarm_q      <= {CHANNELS{1'b0}};
    end else begin
      state_q      <= state_d;
      chan_q       <= chan_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      adc_req_q    <= adc_req_d;
      temp_valid_q <= temp_valid_d;
      temp_chan_q  <= temp_chan_d;
      temp_data_q  <= temp_data_d;
      alarm_q      <= alarm_d;
    end
  end

  assign adc_req    = adc_req_q;
  assign adc_chan   = chan_q;
  assign temp_valid = temp_valid_q;
  assign temp_chan  = temp_chan_q;
  assign temp_data  = temp_data_q;
  assign alarm      = alarm_q;

endmodule

// File: tb/tb_therm_scanner.sv
// Directed and randomized bench for therm_scanner: three instances (default,
// strongly negative and strongly positive gain) share stimulus against a reference model.
module tb_therm_scanner;

  localparam int NCH = 4;
  localparam int N   = 4;
  localparam int NI  = 3;

  logic clk = 1'b0;
  logic rst, enable, adc_valid, temp_ready;
  logic [11:0]        adc_data;
  logic signed [15:0] alarm_hi;

  logic               adc_req_w    [NI];
  logic [1:0]         adc_chan_w   [NI];
  logic               temp_valid_w [NI];
  logic [1:0]         temp_chan_w  [NI];
  logic signed [15:0] temp_data_w  [NI];
  logic [3:0]         alarm_w      [NI];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int gain_m [NI] = '{-100, -1000, 1000};
  bit alarm_m [NI][NCH];
  int chan_m = 0;

  always #5 clk = ~clk;

  therm_scanner u_def (
    .clk(clk), .rst(rst), .enable(enable), .adc_req(adc_req_w[0]), .adc_chan(adc_chan_w[0]),
    .adc_valid(adc_valid), .adc_data(adc_data), .temp_valid(temp_valid_w[0]),
    .temp_ready(temp_ready), .temp_chan(temp_chan_w[0]), .temp_data(temp_data_w[0]),
    .alarm_hi(alarm_hi), .alarm(alarm_w[0]));

  therm_scanner #(.GAIN(-1000)) u_neg (
    .clk(clk), .rst(rst), .enable(enable), .adc_req(adc_req_w[1]), .adc_chan(adc_chan_w[1]),
    .adc_valid(adc_valid), .adc_data(adc_data), .temp_valid(temp_valid_w[1]),
    .temp_ready(temp_ready), .temp_chan(temp_chan_w[1]), .temp_data(temp_data_w[1]),
    .alarm_hi(alarm_hi), .alarm(alarm_w[1]));

  therm_scanner #(.GAIN(1000)) u_pos (
    .clk(clk), .rst(rst), .enable(enable), .adc_req(adc_req_w[2]), .adc_chan(adc_chan_w[2]),
    .adc_valid(adc_valid), .adc_data(adc_data), .temp_valid(temp_valid_w[2]),
    .temp_ready(temp_ready), .temp_chan(temp_chan_w[2]), .temp_data(temp_data_w[2]),
    .alarm_hi(alarm_hi), .alarm(alarm_w[2]));

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Temperature from the arithmetic rules: floor division by 16, offset, clamp to 16 bits.
  function automatic int t_model(input int avg, input int gain);
    longint p, q;
    p = longint'(avg) * longint'(gain);
    q = p / 16;
    if ((p % 16) != 0 && p < 0) q = q - 1;
    q = q + 2000;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return int'(q);
  endfunction

  function automatic logic [3:0] alarm_vec(input int i);
    logic [3:0] v;
    for (int c = 0; c < NCH; c++) v[c] = alarm_m[i][c];
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < NI; i++) begin
      chk({tag, "_adc_req"},    adc_req_w[i],    0);
      chk({tag, "_adc_chan"},   adc_chan_w[i],   0);
      chk({tag, "_temp_valid"}, temp_valid_w[i], 0);
      chk({tag, "_temp_chan"},  temp_chan_w[i],  0);
      chk({tag, "_temp_data"},  temp_data_w[i],  0);
      chk({tag, "_alarm"},      alarm_w[i],      0);
    end
  endtask

  // Feeds one channel's samples, then checks the result, optional backpressure and handshake.
  task automatic do_channel(input int smp [4], input int stall, input int bp, input bit junk, input int drop_at);
    int k, st, cyc, w, sum, avg, hi;
    int exp_t [NI];
    bit acc_now, started_req;
    started_req = adc_req_w[0];
    k = 0; st = 0; cyc = 0;
    while (k < N && cyc < 400) begin
      if (k == drop_at) enable = 1'b0;
      if (adc_req_w[0]) begin
        if (st < stall) begin
          adc_valid = 1'b0;
          st++;
        end else begin
          adc_valid = 1'b1;
          adc_data  = 12'(smp[k]);
        end
      end else begin
        adc_valid = junk;
        adc_data  = 12'hFFF;
      end
      acc_now = adc_req_w[0] && adc_valid;
      tick();
      cyc++;
      if (acc_now) begin
        k++;
        st = 0;
      end
    end
    adc_valid = junk;
    adc_data  = 12'hFFF;
    chk("samples_accepted", k, N);
    chk("req_drop_last", adc_req_w[0], 0);

    sum = smp[0] + smp[1] + smp[2] + smp[3];
    avg = sum / N;
    hi  = int'(alarm_hi);
    for (int i = 0; i < NI; i++) begin
      exp_t[i] = t_model(avg, gain_m[i]);
      if (exp_t[i] >= hi) alarm_m[i][chan_m] = 1'b1;
      else if (exp_t[i] < hi - 50) alarm_m[i][chan_m] = 1'b0;
    end

    w = 0;
    while (!temp_valid_w[0] && w < 20) begin
      tick();
      w++;
    end
    chk("conv_latency", w, 1);
    for (int i = 0; i < NI; i++) begin
      chk("temp_valid", temp_valid_w[i], 1);
      chk("temp_data",  temp_data_w[i],  exp_t[i]);
      chk("temp_chan",  temp_chan_w[i],  chan_m);
      chk("alarm",      alarm_w[i],      alarm_vec(i));
    end

    if (bp > 0) begin
      temp_ready = 1'b0;
      repeat (bp) begin
        tick();
        chk("bp_valid", temp_valid_w[0], 1);
        chk("bp_data",  temp_data_w[0],  exp_t[0]);
        chk("bp_chan",  temp_chan_w[0],  chan_m);
        chk("bp_req",   adc_req_w[0],    0);
      end
      temp_ready = 1'b1;
    end

    tick();
    chk("valid_drop", temp_valid_w[0], 0);
    chk("req_after_hs", adc_req_w[0], enable);
    chan_m = (chan_m + 1) % NCH;
    chk("adc_chan_next", adc_chan_w[0], chan_m);
    if (started_req && stall == 0 && bp == 0) chk("chan_cycles", cyc + w + 1, N + 2);
    adc_valid = 1'b0;
  endtask

  initial begin
    int s [4];
    rst = 1'b1; enable = 1'b0; adc_valid = 1'b0; adc_data = 12'd0;
    temp_ready = 1'b1; alarm_hi = 16'sd32767;
    tick(); tick();
    rst = 1'b0;

    // Idle: no requests even with stray adc_valid pulses.
    for (int c = 0; c < 20; c++) begin
      adc_valid = c[0];
      tick();
      chk("idle_req", adc_req_w[0], 0);
    end
    adc_valid = 1'b0;
    check_reset_outputs("idle");

    enable = 1'b1;
    tick();
    chk("enable_req", adc_req_w[0], 1);

    s = '{160, 160, 160, 160}; do_channel(s, 0, 0, 1'b0, -1);
    s = '{0, 0, 0, 0};         do_channel(s, 0, 0, 1'b0, -1);
    s = '{161, 161, 162, 162}; do_channel(s, 0, 0, 1'b0, -1);
    s = '{4095, 4095, 4095, 4095}; do_channel(s, 0, 0, 1'b0, -1);
    s = '{300, 301, 302, 303}; do_channel(s, 0, 0, 1'b1, -1);

    // Alarm hysteresis on channel 0; channels 1-3 sit well below the threshold.
    alarm_hi = 16'sd1000;
    s = '{200, 200, 200, 200}; do_channel(s, 0, 0, 1'b0, -1);
    do_channel(s, 0, 0, 1'b0, -1);
    do_channel(s, 0, 0, 1'b0, -1);
    s = '{160, 160, 160, 160}; do_channel(s, 0, 0, 1'b0, -1);
    s = '{200, 200, 200, 200}; do_channel(s, 0, 0, 1'b0, -1);
    do_channel(s, 0, 0, 1'b0, -1);
    do_channel(s, 0, 0, 1'b0, -1);
    s = '{166, 166, 166, 166}; do_channel(s, 0, 0, 1'b0, -1);
    s = '{200, 200, 200, 200}; do_channel(s, 0, 0, 1'b0, -1);
    do_channel(s, 0, 0, 1'b0, -1);
    do_channel(s, 0, 0, 1'b0, -1);
    s = '{170, 170, 170, 170}; do_channel(s, 0, 0, 1'b0, -1);

    // Backpressure with stray adc_valid, then stalled samples.
    s = '{1234, 99, 2048, 7};  do_channel(s, 0, 10, 1'b1, -1);
    s = '{161, 161, 162, 162}; do_channel(s, 3, 0, 1'b0, -1);
    s = '{160, 160, 160, 160}; do_channel(s, 3, 0, 1'b1, -1);

    // enable dropped mid-channel: channel completes, FSM idles, pointer retained.
    s = '{500, 600, 700, 800}; do_channel(s, 0, 0, 1'b0, 2);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("drop_idle_req", adc_req_w[0], 0);
      chk("drop_idle_chan", adc_chan_w[0], chan_m);
    end
    enable = 1'b1;
    tick();
    s = '{10, 20, 30, 40}; do_channel(s, 0, 0, 1'b0, -1);

    // Reset after two samples discards the partial average.
    adc_valid = 1'b1; adc_data = 12'd4000;
    tick(); tick();
    adc_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    chan_m = 0;
    for (int i = 0; i < NI; i++)
      for (int c = 0; c < NCH; c++) alarm_m[i][c] = 1'b0;
    tick();
    rst = 1'b0;
    s = '{160, 160, 160, 160}; do_channel(s, 0, 0, 1'b0, -1);

    // Randomized channels, thresholds, stalls and backpressure.
    for (int r = 0; r < 16; r++) begin
      for (int j = 0; j < 4; j++) s[j] = int'($urandom_range(0, 4095));
      alarm_hi = 16'(int'($urandom_range(0, 22000)) - 20000);
      do_channel(s, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
